program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 15 +
 rtl/loader_counter.sv | 37 +++
 rtl/program_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared defaults and FSM state encoding for program_loader
package program_loader_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

endpackage

// File: rtl/loader_counter.sv
// rtl/loader_counter.sv - loadable wrapping address counter
module loader_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority over increment; increment wraps naturally at 2^W.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register, cleared by asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a payload into memory then hands over to run mode; optional checksum via LOADER_CHECKSUM_EN
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write,
    input  logic              halt,
    output logic              op,
    output logic              busy,
    output logic              error
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] addr_cnt;
    logic              addr_load;
    logic              addr_inc;
    logic              xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] chk_sum;
`endif

    loader_counter #(.W(ADDR_W)) u_addr (
        .clk        (clk),
        .rst_n      (reset),
        .load       (addr_load),
        .load_value (base_addr),
        .inc        (addr_inc),
        .count      (addr_cnt)
    );

    assign xfer     = in_valid && in_ready;
    assign in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign op       = (state_q == ST_RUN);
`ifdef LOADER_CHECKSUM_EN
    assign error    = (state_q == ST_ERROR);
    assign chk_sum  = sum_q + in_data;
`else
    assign error    = 1'b0;
`endif
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_write   = mem_write_q;

    // Next-state, counter and write-strobe decisions; halt always wins over start and transfers.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        mem_write_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        addr_load     = 1'b0;
        addr_inc      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !halt) begin
                    state_d   = ST_LOAD;
                    addr_load = 1'b1;
                    rem_d     = load_len;
`ifdef LOADER_CHECKSUM_EN
                    sum_d     = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    mem_write_d   = 1'b1;
                    mem_address_d = addr_cnt;
                    mem_data_d    = in_data;
                    addr_inc      = 1'b1;
                    rem_d         = rem_q - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d         = sum_q + in_data;
`endif
                    // A loaded length of 0 counts down through the full range, giving 2^ADDR_W bytes.
                    if (rem_q == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_RUN;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    state_d = (chk_sum == '0) ? ST_RUN : ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d   = ST_LOAD;
                    addr_load = 1'b1;
                    rem_d     = load_len;
                    sum_d     = '0;
                end
            end
`endif
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending write immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rem_q         <= '0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

endmodule
